// File: rtl/l15_resp_serializer_if.sv
// L1.5 response / narrow refill stream bundle.
// The L1.5 side and the beat stream share one interface instance.
interface l15_resp_serializer_if #(
  parameter int L15_L1D_LINE_SIZE = 64,
  parameter int BEAT_BYTES        = 8,
  parameter int NUM_SLOTS         = 2,
  parameter int THREADID_W        = 1
);
  localparam int BEATS  = L15_L1D_LINE_SIZE / BEAT_BYTES;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(L15_L1D_LINE_SIZE);
  localparam int CNT_W  = $clog2(NUM_SLOTS) + 1;

  logic                           l15_val;
  logic [3:0]                     l15_returntype;
  logic                           l15_nc;
  logic [THREADID_W-1:0]          l15_threadid;
  logic [1:0]                     l15_error;
  logic [OFF_W-1:0]               l15_addr_offset;
  logic [L15_L1D_LINE_SIZE*8-1:0] l15_data;
  logic                           l15_req_ack;

  logic                           out_val;
  logic                           out_rdy;
  logic [BEAT_BYTES*8-1:0]        out_data;
  logic [BIDX_W-1:0]              out_beat_idx;
  logic                           out_first;
  logic                           out_last;
  logic [3:0]                     out_returntype;
  logic [THREADID_W-1:0]          out_threadid;
  logic [1:0]                     out_error;
  logic [CNT_W-1:0]               fifo_count;

  modport master (
    output l15_val, l15_returntype, l15_nc,
    output l15_threadid, l15_error,
    output l15_addr_offset, l15_data,
    input  l15_req_ack,
    input  out_val, out_data, out_beat_idx,
    input  out_first, out_last,
    input  out_returntype, out_threadid,
    input  out_error, fifo_count,
    output out_rdy
  );

  modport slave (
    input  l15_val, l15_returntype, l15_nc,
    input  l15_threadid, l15_error,
    input  l15_addr_offset, l15_data,
    output l15_req_ack,
    output out_val, out_data, out_beat_idx,
    output out_first, out_last,
    output out_returntype, out_threadid,
    output out_error, fifo_count,
    input  out_rdy
  );
endinterface

// File: rtl/l15_resp_serializer.sv
// Buffers whole-line L1.5 responses and replays them as
// fixed-width beats, optionally critical-word-first.
module l15_resp_serializer #(
  parameter int L15_L1D_LINE_SIZE = 64,
  parameter int BEAT_BYTES        = 8,
  parameter int NUM_SLOTS         = 2,
  parameter bit CWF               = 1'b1,
  parameter int THREADID_W        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  l15_resp_serializer_if.slave bus
);
  localparam int BEATS  = L15_L1D_LINE_SIZE / BEAT_BYTES;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(L15_L1D_LINE_SIZE);
  localparam int BSH    = $clog2(BEAT_BYTES);
  localparam int BW     = BEAT_BYTES * 8;
  localparam int LW     = L15_L1D_LINE_SIZE * 8;
  localparam int PTR_W  = $clog2(NUM_SLOTS);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  state_e state_q, state_d;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIDX_W-1:0] beat_q, beat_d;

  logic [LW-1:0]         data_q  [NUM_SLOTS];
  logic [3:0]            rtype_q [NUM_SLOTS];
  logic [THREADID_W-1:0] tid_q   [NUM_SLOTS];
  logic [1:0]            err_q   [NUM_SLOTS];
  logic                  multi_q [NUM_SLOTS];
  logic [BIDX_W-1:0]     start_q [NUM_SLOTS];

  logic              full;
  logic              push;
  logic              pop;
  logic              fire;
  logic              out_val;
  logic              is_fill;
  logic              multi_w;
  logic [LW-1:0]     data_w;
  logic [OFF_W-1:0]  off_sh;
  logic [BIDX_W-1:0] start_w;
  logic [BIDX_W:0]   idx_sum;
  logic [BIDX_W-1:0] idx;
  logic [BIDX_W-1:0] last_n;
  logic              is_last;
  logic [LW-1:0]     head_line;

  // Full comes from registered occupancy only, so a same-cycle pop
  // never frees a slot for a push.
  assign full = (cnt_q == CNT_W'(NUM_SLOTS));
  assign push = bus.l15_val & ~full & ~rst;
  assign bus.l15_req_ack = push;

  assign is_fill = (bus.l15_returntype == 4'b0000) |
                   (bus.l15_returntype == 4'b0001);
  assign multi_w = is_fill & ~bus.l15_nc;
  assign data_w  = is_fill ? bus.l15_data : '0;
  assign off_sh  = bus.l15_addr_offset >> BSH;
  assign start_w = CWF ? off_sh[BIDX_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q]  <= data_w;
      rtype_q[wr_ptr_q] <= bus.l15_returntype;
      tid_q[wr_ptr_q]   <= bus.l15_threadid;
      err_q[wr_ptr_q]   <= bus.l15_error;
      multi_q[wr_ptr_q] <= multi_w;
      start_q[wr_ptr_q] <= start_w;
    end
  end

  assign out_val   = (state_q == STREAM);
  assign head_line = data_q[rd_ptr_q];

  // Line position wraps mod BEATS, which need not be a power of two.
  always_comb begin
    idx_sum = {1'b0, start_q[rd_ptr_q]} + {1'b0, beat_q};
    if (idx_sum >= (BIDX_W+1)'(BEATS)) begin
      idx_sum = idx_sum - (BIDX_W+1)'(BEATS);
    end
    idx = idx_sum[BIDX_W-1:0];
  end

  assign last_n  = multi_q[rd_ptr_q] ? BIDX_W'(BEATS - 1) : '0;
  assign is_last = (beat_q == last_n);
  assign fire    = out_val & bus.out_rdy;
  assign pop     = fire & is_last;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    state_d  = state_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fire) begin
      if (is_last) begin
        beat_d   = '0;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    unique case (state_q)
      IDLE: begin
        if (push) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (pop && !push && cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
    end
  end

  // Outputs are forced to zero whenever nothing is queued.
  always_comb begin
    bus.out_val        = out_val;
    bus.out_data       = '0;
    bus.out_beat_idx   = '0;
    bus.out_first      = 1'b0;
    bus.out_last       = 1'b0;
    bus.out_returntype = '0;
    bus.out_threadid   = '0;
    bus.out_error      = '0;
    if (out_val) begin
      bus.out_data       = head_line[int'(idx)*BW +: BW];
      bus.out_beat_idx   = idx;
      bus.out_first      = (beat_q == '0);
      bus.out_last       = is_last;
      bus.out_returntype = rtype_q[rd_ptr_q];
      bus.out_threadid   = tid_q[rd_ptr_q];
      bus.out_error      = err_q[rd_ptr_q];
    end
  end

  assign bus.fifo_count = cnt_q;

endmodule

// File: tb/tb_l15_resp_serializer.sv
// Scoreboard bench: one CWF=1 and one CWF=0 instance share stimulus.
// Expected beats are derived from the line/offset rules directly.
module tb_l15_resp_serializer;
  localparam int LINE  = 64;
  localparam int BB    = 8;
  localparam int NS    = 2;
  localparam int TW    = 1;
  localparam int BEATS = LINE / BB;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  idx;
    logic        first;
    logic        last;
    logic [3:0]  rt;
    logic [0:0]  tid;
    logic [1:0]  err;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         val;
  logic [3:0]   rt_s;
  logic         nc_s;
  logic [0:0]   tid_s;
  logic [1:0]   err_s;
  logic [5:0]   off_s;
  logic [511:0] line_s;
  logic         rdy;

  l15_resp_serializer_if #(
    .L15_L1D_LINE_SIZE(LINE), .BEAT_BYTES(BB),
    .NUM_SLOTS(NS), .THREADID_W(TW)
  ) bus0 ();
  l15_resp_serializer_if #(
    .L15_L1D_LINE_SIZE(LINE), .BEAT_BYTES(BB),
    .NUM_SLOTS(NS), .THREADID_W(TW)
  ) bus1 ();

  assign bus0.l15_val = val;
  assign bus0.l15_returntype = rt_s;
  assign bus0.l15_nc = nc_s;
  assign bus0.l15_threadid = tid_s;
  assign bus0.l15_error = err_s;
  assign bus0.l15_addr_offset = off_s;
  assign bus0.l15_data = line_s;
  assign bus0.out_rdy = rdy;
  assign bus1.l15_val = val;
  assign bus1.l15_returntype = rt_s;
  assign bus1.l15_nc = nc_s;
  assign bus1.l15_threadid = tid_s;
  assign bus1.l15_error = err_s;
  assign bus1.l15_addr_offset = off_s;
  assign bus1.l15_data = line_s;
  assign bus1.out_rdy = rdy;

  l15_resp_serializer #(
    .L15_L1D_LINE_SIZE(LINE), .BEAT_BYTES(BB), .NUM_SLOTS(NS),
    .CWF(1'b0), .THREADID_W(TW)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  l15_resp_serializer #(
    .L15_L1D_LINE_SIZE(LINE), .BEAT_BYTES(BB), .NUM_SLOTS(NS),
    .CWF(1'b1), .THREADID_W(TW)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad = 0;
  beat_t q0[$];
  beat_t q1[$];

  beat_t       prev [2];
  logic        hold [2];
  int          fires [2];
  int          firsts [2];
  logic [63:0] first_data [2];
  int          first_idx [2];
  logic [63:0] last_data [2];
  int          last_idx [2];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", nm, got, exp);
    end
  endtask

  // Reference: beat count, start beat and slice straight from the rules.
  task automatic model_push(input logic [3:0] rt, input logic nc,
                            input logic [0:0] tid, input logic [1:0] err,
                            input logic [5:0] off, input logic [511:0] ln);
    bit fill;
    int nb;
    int st;
    int ix;
    beat_t b;
    fill = (rt == 4'd0) || (rt == 4'd1);
    nb = (fill && !nc) ? BEATS : 1;
    for (int cwf = 0; cwf < 2; cwf++) begin
      st = (cwf == 1) ? (int'(off) / BB) : 0;
      for (int n = 0; n < nb; n++) begin
        ix = (st + n) % BEATS;
        b.data = fill ? ln[ix*64 +: 64] : 64'd0;
        b.idx = 3'(ix);
        b.first = (n == 0);
        b.last = (n == nb - 1);
        b.rt = rt;
        b.tid = tid;
        b.err = err;
        if (cwf == 1) q1.push_back(b);
        else q0.push_back(b);
      end
    end
  endtask

  task automatic mon(input int w, input logic v, input logic r,
                     input beat_t got);
    beat_t e;
    if (rst) begin
      hold[w] = 1'b0;
      return;
    end
    if (hold[w]) begin
      total++;
      if (!v || got !== prev[w]) begin
        bad++;
        $display("FAIL hold dut%0d got=%h required=%h", w, got, prev[w]);
      end
    end
    hold[w] = v && !r;
    prev[w] = got;
    if (v && r) begin
      fires[w]++;
      total++;
      if ((w == 1 ? q1.size() : q0.size()) == 0) begin
        bad++;
        $display("FAIL beat dut%0d got=%h required=none", w, got);
      end else begin
        e = (w == 1) ? q1.pop_front() : q0.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL beat dut%0d got=%h required=%h", w, got, e);
        end
      end
      if (got.first) begin
        firsts[w]++;
        first_data[w] = got.data;
        first_idx[w] = int'(got.idx);
      end
      if (got.last) begin
        last_data[w] = got.data;
        last_idx[w] = int'(got.idx);
      end
    end
  endtask

  always @(negedge clk)
    mon(0, bus0.out_val, bus0.out_rdy,
        {bus0.out_data, bus0.out_beat_idx, bus0.out_first,
         bus0.out_last, bus0.out_returntype, bus0.out_threadid,
         bus0.out_error});

  always @(negedge clk)
    mon(1, bus1.out_val, bus1.out_rdy,
        {bus1.out_data, bus1.out_beat_idx, bus1.out_first,
         bus1.out_last, bus1.out_returntype, bus1.out_threadid,
         bus1.out_error});

  // Called at posedge+2; returns at posedge+2 after val drops.
  task automatic send(input logic [3:0] rt, input logic nc,
                      input logic [0:0] tid, input logic [1:0] err,
                      input logic [5:0] off, input logic [511:0] ln,
                      output int waited);
    rt_s = rt; nc_s = nc; tid_s = tid;
    err_s = err; off_s = off; line_s = ln;
    val = 1'b1;
    waited = 0;
    forever begin
      #1;
      if (bus1.l15_req_ack || bus0.l15_req_ack) begin
        chk("ack_agree", 64'(bus0.l15_req_ack), 64'(bus1.l15_req_ack));
        model_push(rt, nc, tid, err, off, ln);
        break;
      end
      waited++;
      if (waited > 200) begin
        chk("ack_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #2;
    val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q0.size() != 0 || q1.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > 2000) begin
        chk("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
        q0.delete();
        q1.delete();
        break;
      end
    end
    @(posedge clk); #2;
  endtask

  function automatic logic [511:0] ramp();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = 8'(i);
    return r;
  endfunction

  function automatic logic [511:0] rnd_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  int w;
  int f0;
  int f1;
  int fs0;
  bit rdone;

  initial begin
    rst = 1'b1; val = 1'b0; rdy = 1'b0;
    rt_s = '0; nc_s = 1'b0; tid_s = '0; err_s = '0;
    off_s = '0; line_s = '0;
    for (int i = 0; i < 2; i++) begin
      hold[i] = 1'b0; fires[i] = 0; firsts[i] = 0;
      first_data[i] = '0; first_idx[i] = 0;
      last_data[i] = '0; last_idx[i] = 0;
    end
    repeat (2) @(posedge clk);
    #2;
    val = 1'b1;
    #1;
    chk("rst_ack", 64'(bus1.l15_req_ack), 64'd0);
    chk("rst_val", 64'(bus1.out_val), 64'd0);
    chk("rst_cnt", 64'(bus1.fifo_count), 64'd0);
    chk("rst_data", bus1.out_data, 64'd0);
    @(posedge clk); #2;
    val = 1'b0;
    rst = 1'b0;
    @(posedge clk); #2;

    // critical-word-first cacheable load
    rdy = 1'b1;
    send(4'd0, 1'b0, 1'b1, 2'd0, 6'h28, ramp(), w);
    drain();
    chk("cwf_first_data", first_data[1], 64'h2F2E2D2C2B2A2928);
    chk("cwf_first_idx", 64'(first_idx[1]), 64'd5);
    chk("cwf_last_idx", 64'(last_idx[1]), 64'd4);
    chk("lin_first_idx", 64'(first_idx[0]), 64'd0);
    chk("lin_last_idx", 64'(last_idx[0]), 64'd7);
    chk("lin_last_data", last_data[0], 64'h3F3E3D3C3B3A3938);
    chk("empty_after", 64'(bus1.fifo_count), 64'd0);

    // nc load and store ack
    send(4'd0, 1'b1, 1'b0, 2'd1, 6'h10, ramp(), w);
    drain();
    chk("nc_data", first_data[1], 64'h1716151413121110);
    chk("nc_idx", 64'(first_idx[1]), 64'd2);
    chk("nc_last_idx", 64'(last_idx[1]), 64'd2);
    send(4'd4, 1'b0, 1'b0, 2'd0, 6'h10, ramp(), w);
    drain();
    chk("st_data", first_data[1], 64'd0);

    // full FIFO holds off the third response
    rdy = 1'b0;
    send(4'd0, 1'b0, 1'b0, 2'd0, 6'h00, rnd_line(), w);
    chk("full_wait_a", 64'(w), 64'd0);
    send(4'd1, 1'b0, 1'b1, 2'd2, 6'h08, rnd_line(), w);
    chk("full_wait_b", 64'(w), 64'd0);
    fork
      send(4'd0, 1'b0, 1'b0, 2'd3, 6'h30, rnd_line(), w);
      begin
        repeat (4) @(posedge clk);
        #3;
        chk("full_cnt1", 64'(bus1.fifo_count), 64'd2);
        chk("full_cnt0", 64'(bus0.fifo_count), 64'd2);
        @(posedge clk); #2;
        rdy = 1'b1;
      end
    join
    chk("full_wait_c", 64'(w), 64'd13);
    drain();

    // two queued entries stream back to back
    rdy = 1'b0;
    send(4'd0, 1'b0, 1'b0, 2'd0, 6'h18, rnd_line(), w);
    send(4'd1, 1'b0, 1'b1, 2'd1, 6'h3C, rnd_line(), w);
    f0 = fires[0]; f1 = fires[1]; fs0 = firsts[1];
    rdy = 1'b1;
    repeat (16) @(posedge clk);
    #3;
    chk("bb_fires1", 64'(fires[1] - f1), 64'd16);
    chk("bb_fires0", 64'(fires[0] - f0), 64'd16);
    chk("bb_firsts", 64'(firsts[1] - fs0), 64'd2);
    chk("bb_val", 64'(bus1.out_val), 64'd0);
    @(posedge clk); #2;

    // reset in the middle of a burst
    f1 = fires[1];
    send(4'd0, 1'b0, 1'b0, 2'd0, 6'h18, rnd_line(), w);
    repeat (3) begin @(posedge clk); #2; end
    rst = 1'b1;
    rdy = 1'b0;
    q0.delete();
    q1.delete();
    chk("mid_fires", 64'(fires[1] - f1), 64'd3);
    @(posedge clk); #3;
    chk("mid_val1", 64'(bus1.out_val), 64'd0);
    chk("mid_val0", 64'(bus0.out_val), 64'd0);
    chk("mid_cnt", 64'(bus1.fifo_count), 64'd0);
    rst = 1'b0;
    @(posedge clk); #2;
    rdy = 1'b1;
    send(4'd1, 1'b0, 1'b1, 2'd0, 6'h38, rnd_line(), w);
    drain();
    chk("post_rst_idx1", 64'(first_idx[1]), 64'd7);
    chk("post_rst_idx0", 64'(first_idx[0]), 64'd0);

    // random traffic with random back-pressure
    rdone = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [3:0] rt;
          if ($urandom_range(0, 3) == 0) rt = 4'($urandom);
          else rt = 4'($urandom_range(0, 1));
          send(rt, ($urandom_range(0, 3) == 0), 1'($urandom),
               2'($urandom), 6'($urandom), rnd_line(), w);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #2;
          rdy = ($urandom_range(0, 9) < 7);
        end
      end
    join
    rdy = 1'b1;
    drain();
    chk("end_q0", 64'(q0.size()), 64'd0);
    chk("end_q1", 64'(q1.size()), 64'd0);
    chk("end_cnt", 64'(bus1.fifo_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
